soc_miner_axi_mem_slave: RTL and testbench

AXI3 burst slave backed by on-chip dual-port RAM; the responder end of the soc_miner `m_memory_*` master port. It accepts INCR/FIXED bursts of 64-bit beats, serves reads and writes through independent FSMs, and returns per-burst OKAY/SLVERR responses. It is used as a standalone scratch memory and as the memory model in system benches.

---
 rtl/soc_miner_axi_mem_slave.sv | 218 +++++++++++++++++++++
 tb/tb_soc_miner_axi_mem_slave.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_miner_axi_mem_slave.sv
// AXI3 burst slave over an on-chip RAM of 64-bit words: independent write and
// read FSMs, INCR/FIXED bursts, per-burst OKAY/SLVERR, all outputs registered.
module soc_miner_axi_mem_slave #(
  parameter int MEMORY_DATA_WIDTH    = 64,
  parameter int MEMORY_ADDR_WIDTH    = 32,
  parameter int MEMORY_BUS_LEN_WIDTH = 4,
  parameter int MEMORY_ID_WIDTH      = 6,
  parameter int MEM_DEPTH_LOG2       = 10
) (
  input  logic                            Clk,
  input  logic                            Rst,
  // write address
  input  logic                            s_memory_awvalid,
  input  logic [MEMORY_ADDR_WIDTH-1:0]    s_memory_awaddr,
  input  logic [MEMORY_BUS_LEN_WIDTH-1:0] s_memory_awlen,
  input  logic [MEMORY_ID_WIDTH-1:0]      s_memory_awid,
  input  logic [2:0]                      s_memory_awsize,
  input  logic [1:0]                      s_memory_awburst,
  input  logic [1:0]                      s_memory_awlock,
  input  logic [3:0]                      s_memory_awcache,
  input  logic [2:0]                      s_memory_awprot,
  input  logic [3:0]                      s_memory_awqos,
  output logic                            s_memory_awready,
  // write data
  input  logic                            s_memory_wvalid,
  input  logic [MEMORY_DATA_WIDTH-1:0]    s_memory_wdata,
  input  logic [MEMORY_DATA_WIDTH/8-1:0]  s_memory_wstrb,
  input  logic                            s_memory_wlast,
  input  logic [MEMORY_ID_WIDTH-1:0]      s_memory_wid,
  output logic                            s_memory_wready,
  // write response
  output logic                            s_memory_bvalid,
  output logic [1:0]                      s_memory_bresp,
  output logic [MEMORY_ID_WIDTH-1:0]      s_memory_bid,
  input  logic                            s_memory_bready,
  // read address
  input  logic                            s_memory_arvalid,
  input  logic [MEMORY_ADDR_WIDTH-1:0]    s_memory_araddr,
  input  logic [MEMORY_BUS_LEN_WIDTH-1:0] s_memory_arlen,
  input  logic [MEMORY_ID_WIDTH-1:0]      s_memory_arid,
  input  logic [2:0]                      s_memory_arsize,
  input  logic [1:0]                      s_memory_arburst,
  input  logic [1:0]                      s_memory_arlock,
  input  logic [3:0]                      s_memory_arcache,
  input  logic [2:0]                      s_memory_arprot,
  input  logic [3:0]                      s_memory_arqos,
  output logic                            s_memory_arready,
  // read data
  output logic                            s_memory_rvalid,
  output logic [MEMORY_DATA_WIDTH-1:0]    s_memory_rdata,
  output logic                            s_memory_rlast,
  output logic [1:0]                      s_memory_rresp,
  output logic [MEMORY_ID_WIDTH-1:0]      s_memory_rid,
  input  logic                            s_memory_rready
);

  localparam int STRB_W = MEMORY_DATA_WIDTH / 8;
  localparam int DEPTH  = 1 << MEM_DEPTH_LOG2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  typedef logic [MEM_DEPTH_LOG2-1:0]       idx_t;
  typedef logic [MEMORY_BUS_LEN_WIDTH-1:0] len_t;

  function automatic logic burst_legal(input logic [1:0] burst, input logic [2:0] size);
    return ((burst == BURST_INCR) || (burst == BURST_FIXED)) && (size == 3'b011);
  endfunction

  logic [MEMORY_DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------------------------------------------------------- write side
  w_state_t w_state, w_state_next;
  idx_t     w_idx;
  len_t     w_len, w_beat;
  logic     w_fixed, w_legal, w_err;
  logic     aw_hs, w_hs, b_hs, w_last_beat, wlast_bad;

  assign aw_hs       = s_memory_awvalid & s_memory_awready;
  assign w_hs        = s_memory_wvalid & s_memory_wready;
  assign b_hs        = s_memory_bvalid & s_memory_bready;
  assign w_last_beat = (w_beat == w_len);
  assign wlast_bad   = (s_memory_wlast != w_last_beat);

  always_comb begin
    w_state_next = w_state;
    unique case (w_state)
      W_IDLE:  if (aw_hs) w_state_next = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_state_next = W_RESP;
      W_RESP:  if (b_hs) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the next state, so every
  // ready/valid comes straight from a flop.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      w_state          <= W_IDLE;
      w_idx            <= '0;
      w_len            <= '0;
      w_beat           <= '0;
      w_fixed          <= 1'b0;
      w_legal          <= 1'b0;
      w_err            <= 1'b0;
      s_memory_awready <= 1'b0;
      s_memory_wready  <= 1'b0;
      s_memory_bvalid  <= 1'b0;
      s_memory_bresp   <= RESP_OKAY;
      s_memory_bid     <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      w_state          <= w_state_next;
      s_memory_awready <= (w_state_next == W_IDLE);
      s_memory_wready  <= (w_state_next == W_DATA);
      s_memory_bvalid  <= (w_state_next == W_RESP);
      if (aw_hs) begin
        w_idx        <= s_memory_awaddr[MEM_DEPTH_LOG2+2:3];
        w_len        <= s_memory_awlen;
        w_beat       <= '0;
        w_fixed      <= (s_memory_awburst == BURST_FIXED);
        w_legal      <= burst_legal(s_memory_awburst, s_memory_awsize);
        w_err        <= 1'b0;
        s_memory_bid <= s_memory_awid;
      end
      if (w_hs) begin
        w_beat <= w_beat + 1'b1;
        w_err  <= w_err | wlast_bad;
        if (!w_fixed) w_idx <= w_idx + 1'b1;
        if (w_last_beat)
          s_memory_bresp <= (!w_legal || w_err || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // NOTE: the RAM array has no reset; contents survive Rst and only the
  // control path is cleared.
  always_ff @(posedge Clk) begin
    if (w_hs && w_legal && !Rst) begin
      for (int b = 0; b < STRB_W; b++)
        if (s_memory_wstrb[b]) mem[w_idx][8*b +: 8] <= s_memory_wdata[8*b +: 8];
    end
  end

  // ----------------------------------------------------------------- read side
  r_state_t r_state, r_state_next;
  idx_t     r_idx;
  len_t     r_len, r_beat;
  logic     r_fixed, r_legal;
  logic     ar_hs, r_hs;

  assign ar_hs = s_memory_arvalid & s_memory_arready;
  assign r_hs  = s_memory_rvalid & s_memory_rready;

  always_comb begin
    r_state_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs) r_state_next = R_FETCH;
      R_FETCH: r_state_next = R_DATA;
      R_DATA:  if (r_hs) r_state_next = s_memory_rlast ? R_IDLE : R_FETCH;
      default: r_state_next = R_IDLE;
    endcase
  end

  // The RAM is read here while the write port updates it with non-blocking
  // assignments, so a same-cycle collision returns the old word.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state          <= R_IDLE;
      r_idx            <= '0;
      r_len            <= '0;
      r_beat           <= '0;
      r_fixed          <= 1'b0;
      r_legal          <= 1'b0;
      s_memory_arready <= 1'b0;
      s_memory_rvalid  <= 1'b0;
      s_memory_rdata   <= '0;
      s_memory_rlast   <= 1'b0;
      s_memory_rresp   <= RESP_OKAY;
      s_memory_rid     <= '0;
    end else begin
      r_state          <= r_state_next;
      s_memory_arready <= (r_state_next == R_IDLE);
      s_memory_rvalid  <= (r_state_next == R_DATA);
      if (ar_hs) begin
        r_idx        <= s_memory_araddr[MEM_DEPTH_LOG2+2:3];
        r_len        <= s_memory_arlen;
        r_beat       <= '0;
        r_fixed      <= (s_memory_arburst == BURST_FIXED);
        r_legal      <= burst_legal(s_memory_arburst, s_memory_arsize);
        s_memory_rid <= s_memory_arid;
      end
      if (r_state == R_FETCH) begin
        s_memory_rdata <= r_legal ? mem[r_idx] : '0;
        s_memory_rlast <= (r_beat == r_len);
        s_memory_rresp <= r_legal ? RESP_OKAY : RESP_SLVERR;
      end
      if (r_hs && !s_memory_rlast) begin
        r_beat <= r_beat + 1'b1;
        if (!r_fixed) r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Sideband fields and address bits outside the word index are ignored.
  logic unused_ok;
  assign unused_ok = ^{s_memory_awlock, s_memory_awcache, s_memory_awprot, s_memory_awqos,
                       s_memory_arlock, s_memory_arcache, s_memory_arprot, s_memory_arqos,
                       s_memory_wid,
                       s_memory_awaddr[2:0], s_memory_awaddr[MEMORY_ADDR_WIDTH-1:MEM_DEPTH_LOG2+3],
                       s_memory_araddr[2:0], s_memory_araddr[MEMORY_ADDR_WIDTH-1:MEM_DEPTH_LOG2+3]};

endmodule

// File: tb/tb_soc_miner_axi_mem_slave.sv
// Directed bench for soc_miner_axi_mem_slave: one task per scenario, inline
// comparisons against hand-computed values, one summary line at the end.
module tb_soc_miner_axi_mem_slave;

  logic        Clk, Rst;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, araddr;
  logic [3:0]  awlen, arlen, awcache, arcache, awqos, arqos;
  logic [5:0]  awid, arid, wid, bid, rid;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, awlock, arlock, bresp, rresp;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;
  logic        arvalid, arready, rvalid, rready, rlast;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] wbuf [16];
  logic [63:0] rbuf [16];
  logic        lbuf [16];
  logic [1:0]  pbuf [16];

  soc_miner_axi_mem_slave dut (
    .Clk(Clk), .Rst(Rst),
    .s_memory_awvalid(awvalid), .s_memory_awaddr(awaddr), .s_memory_awlen(awlen),
    .s_memory_awid(awid), .s_memory_awsize(awsize), .s_memory_awburst(awburst),
    .s_memory_awlock(awlock), .s_memory_awcache(awcache), .s_memory_awprot(awprot),
    .s_memory_awqos(awqos), .s_memory_awready(awready),
    .s_memory_wvalid(wvalid), .s_memory_wdata(wdata), .s_memory_wstrb(wstrb),
    .s_memory_wlast(wlast), .s_memory_wid(wid), .s_memory_wready(wready),
    .s_memory_bvalid(bvalid), .s_memory_bresp(bresp), .s_memory_bid(bid),
    .s_memory_bready(bready),
    .s_memory_arvalid(arvalid), .s_memory_araddr(araddr), .s_memory_arlen(arlen),
    .s_memory_arid(arid), .s_memory_arsize(arsize), .s_memory_arburst(arburst),
    .s_memory_arlock(arlock), .s_memory_arcache(arcache), .s_memory_arprot(arprot),
    .s_memory_arqos(arqos), .s_memory_arready(arready),
    .s_memory_rvalid(rvalid), .s_memory_rdata(rdata), .s_memory_rlast(rlast),
    .s_memory_rresp(rresp), .s_memory_rid(rid), .s_memory_rready(rready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic timeout(input string what);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting for handshake", what);
  endtask

  task automatic wait_for(input string what, ref logic sig);
    int guard = 0;
    while (sig !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    if (sig !== 1'b1) timeout(what);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [3:0] len, input logic [5:0] id,
                           input logic [1:0] burst, input logic [2:0] size, input logic [7:0] strb,
                           input int early_last, output logic [1:0] resp_o, output logic [5:0] bid_o);
    awaddr = addr; awlen = len; awid = id; awburst = burst; awsize = size; awvalid = 1'b1;
    wait_for("awready", awready);
    tick();
    awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wvalid = 1'b1;
      wdata  = wbuf[b];
      wstrb  = strb;
      wlast  = (early_last >= 0) ? (b == early_last) : (b == int'(len));
      wait_for("wready", wready);
      tick();
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    bready = 1'b1;
    wait_for("bvalid", bvalid);
    resp_o = bresp;
    bid_o  = bid;
    tick();
    bready = 1'b0;
  endtask

  // lat_o = rising edges from the ar handshake edge until rvalid is seen.
  task automatic axi_read(input logic [31:0] addr, input logic [3:0] len, input logic [5:0] id,
                          input logic [1:0] burst, input logic [2:0] size,
                          output int lat_o, output logic [5:0] rid_o);
    int guard;
    araddr = addr; arlen = len; arid = id; arburst = burst; arsize = size; arvalid = 1'b1;
    wait_for("arready", arready);
    tick();
    arvalid = 1'b0;
    rready  = 1'b1;
    lat_o   = 0;
    rid_o   = '0;
    for (int b = 0; b <= int'(len); b++) begin
      guard = 0;
      while (rvalid !== 1'b1 && guard < 20) begin
        tick();
        guard++;
      end
      if (rvalid !== 1'b1) timeout("rvalid");
      if (b == 0) lat_o = guard;
      rbuf[b] = rdata;
      lbuf[b] = rlast;
      pbuf[b] = rresp;
      rid_o   = rid;
      tick();
    end
    rready = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    tick();
    tick();
    if ({awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rlast, rresp, rid} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0",
               {awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rlast, rresp, rid});
    end
    n_cmp++;
    Rst = 1'b0;
    tick();
    if ({awready, arready} !== 2'b11) begin
      n_err++;
      $display("FAIL idle_ready: got %b want 11", {awready, arready});
    end
    n_cmp++;
    if ({wready, bvalid, bresp, bid, rvalid, rdata, rlast, rresp, rid} !== '0) begin
      n_err++;
      $display("FAIL idle_others: got %h want 0",
               {wready, bvalid, bresp, bid, rvalid, rdata, rlast, rresp, rid});
    end
    n_cmp++;
  endtask

  task automatic test_incr();
    logic [1:0]  resp;
    logic [5:0]  id_o;
    int          lat;
    logic [63:0] exp_d [4];
    exp_d[0] = 64'h1111_1111_1111_1111;
    exp_d[1] = 64'h2222_2222_2222_2222;
    exp_d[2] = 64'h3333_3333_3333_3333;
    exp_d[3] = 64'h4444_4444_4444_4444;
    for (int i = 0; i < 4; i++) wbuf[i] = exp_d[i];
    axi_write(32'h100, 4'd3, 6'd5, 2'b01, 3'b011, 8'hFF, -1, resp, id_o);
    if (resp !== 2'b00 || id_o !== 6'd5) begin
      n_err++;
      $display("FAIL incr_bresp: got resp=%b id=%0d want resp=00 id=5", resp, id_o);
    end
    n_cmp++;
    axi_read(32'h100, 4'd3, 6'd5, 2'b01, 3'b011, lat, id_o);
    if (lat !== 1) begin
      n_err++;
      $display("FAIL incr_read_latency: got %0d want 1", lat);
    end
    n_cmp++;
    if (id_o !== 6'd5) begin
      n_err++;
      $display("FAIL incr_rid: got %0d want 5", id_o);
    end
    n_cmp++;
    for (int i = 0; i < 4; i++) begin
      if (rbuf[i] !== exp_d[i] || lbuf[i] !== (i == 3) || pbuf[i] !== 2'b00) begin
        n_err++;
        $display("FAIL incr_beat%0d: got d=%h last=%b resp=%b want d=%h last=%b resp=00",
                 i, rbuf[i], lbuf[i], pbuf[i], exp_d[i], (i == 3));
      end
      n_cmp++;
    end
  endtask

  task automatic test_strobe();
    logic [1:0] resp;
    logic [5:0] id_o;
    int         lat;
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    axi_write(32'h0, 4'd0, 6'd1, 2'b01, 3'b011, 8'hFF, -1, resp, id_o);
    wbuf[0] = 64'h0;
    axi_write(32'h0, 4'd0, 6'd1, 2'b01, 3'b011, 8'h0F, -1, resp, id_o);
    axi_read(32'h0, 4'd0, 6'd1, 2'b01, 3'b011, lat, id_o);
    if (rbuf[0] !== 64'hFFFF_FFFF_0000_0000 || lbuf[0] !== 1'b1) begin
      n_err++;
      $display("FAIL strobe_merge: got d=%h last=%b want d=ffffffff00000000 last=1", rbuf[0], lbuf[0]);
    end
    n_cmp++;
  endtask

  task automatic test_wrap();
    logic [1:0] resp;
    logic [5:0] id_o;
    int         lat;
    for (int i = 0; i < 4; i++) wbuf[i] = 64'hA0A0_0000_0000_0000 + 64'(i);
    // word 1022 = byte address 0x1FF0
    axi_write(32'h1FF0, 4'd3, 6'd2, 2'b01, 3'b011, 8'hFF, -1, resp, id_o);
    axi_read(32'h1FF0, 4'd1, 6'd2, 2'b01, 3'b011, lat, id_o);
    if (rbuf[0] !== 64'hA0A0_0000_0000_0000 || rbuf[1] !== 64'hA0A0_0000_0000_0001) begin
      n_err++;
      $display("FAIL wrap_top_words: got %h %h want a0a0000000000000 a0a0000000000001", rbuf[0], rbuf[1]);
    end
    n_cmp++;
    axi_read(32'h0, 4'd1, 6'd2, 2'b01, 3'b011, lat, id_o);
    if (rbuf[0] !== 64'hA0A0_0000_0000_0002 || rbuf[1] !== 64'hA0A0_0000_0000_0003) begin
      n_err++;
      $display("FAIL wrap_low_words: got %h %h want a0a0000000000002 a0a0000000000003", rbuf[0], rbuf[1]);
    end
    n_cmp++;
    axi_read(32'h8, 4'd2, 6'd3, 2'b00, 3'b011, lat, id_o);
    for (int i = 0; i < 3; i++) begin
      if (rbuf[i] !== 64'hA0A0_0000_0000_0003 || lbuf[i] !== (i == 2)) begin
        n_err++;
        $display("FAIL fixed_beat%0d: got d=%h last=%b want d=a0a0000000000003 last=%b",
                 i, rbuf[i], lbuf[i], (i == 2));
      end
      n_cmp++;
    end
    // 0x2008 aliases word 1
    axi_read(32'h2008, 4'd0, 6'd3, 2'b01, 3'b011, lat, id_o);
    if (rbuf[0] !== 64'hA0A0_0000_0000_0003) begin
      n_err++;
      $display("FAIL alias_read: got %h want a0a0000000000003", rbuf[0]);
    end
    n_cmp++;
  endtask

  task automatic test_illegal();
    logic [1:0] resp;
    logic [5:0] id_o;
    int         lat;
    wbuf[0] = 64'h5555_5555_5555_5555;
    axi_write(32'h200, 4'd0, 6'd7, 2'b01, 3'b011, 8'hFF, -1, resp, id_o);
    wbuf[0] = 64'hDEAD_BEEF_DEAD_BEEF;
    axi_write(32'h200, 4'd0, 6'd9, 2'b10, 3'b011, 8'hFF, -1, resp, id_o);
    if (resp !== 2'b10 || id_o !== 6'd9) begin
      n_err++;
      $display("FAIL illegal_bresp: got resp=%b id=%0d want resp=10 id=9", resp, id_o);
    end
    n_cmp++;
    axi_read(32'h200, 4'd0, 6'd7, 2'b01, 3'b011, lat, id_o);
    if (rbuf[0] !== 64'h5555_5555_5555_5555) begin
      n_err++;
      $display("FAIL illegal_write_suppressed: got %h want 5555555555555555", rbuf[0]);
    end
    n_cmp++;
    axi_read(32'h100, 4'd1, 6'd4, 2'b01, 3'b010, lat, id_o);
    for (int i = 0; i < 2; i++) begin
      if (rbuf[i] !== 64'h0 || pbuf[i] !== 2'b10 || lbuf[i] !== (i == 1)) begin
        n_err++;
        $display("FAIL illegal_read_beat%0d: got d=%h resp=%b last=%b want d=0 resp=10 last=%b",
                 i, rbuf[i], pbuf[i], lbuf[i], (i == 1));
      end
      n_cmp++;
    end
  endtask

  task automatic test_stall();
    logic [63:0] exp_d [4];
    exp_d[0] = 64'h1111_1111_1111_1111;
    exp_d[1] = 64'h2222_2222_2222_2222;
    exp_d[2] = 64'h3333_3333_3333_3333;
    exp_d[3] = 64'h4444_4444_4444_4444;
    araddr = 32'h100; arlen = 4'd3; arid = 6'd6; arburst = 2'b01; arsize = 3'b011; arvalid = 1'b1;
    rready = 1'b0;
    wait_for("arready", arready);
    tick();
    arvalid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      wait_for("rvalid", rvalid);
      if (b == 1) begin
        for (int s = 0; s < 5; s++) begin
          tick();
          if (rvalid !== 1'b1 || rdata !== exp_d[1] || rlast !== 1'b0) begin
            n_err++;
            $display("FAIL stall_hold%0d: got v=%b d=%h last=%b want v=1 d=%h last=0",
                     s, rvalid, rdata, rlast, exp_d[1]);
          end
          n_cmp++;
        end
      end
      if (rdata !== exp_d[b] || rlast !== (b == 3)) begin
        n_err++;
        $display("FAIL stall_beat%0d: got d=%h last=%b want d=%h last=%b", b, rdata, rlast, exp_d[b], (b == 3));
      end
      n_cmp++;
      rready = 1'b1;
      tick();
      rready = 1'b0;
    end
  endtask

  task automatic test_early_wlast();
    logic [1:0] resp;
    logic [5:0] id_o;
    int         lat;
    for (int i = 0; i < 4; i++) wbuf[i] = 64'hC0C0_0000_0000_0000 + 64'(i);
    axi_write(32'h300, 4'd3, 6'd11, 2'b01, 3'b011, 8'hFF, 1, resp, id_o);
    if (resp !== 2'b10 || id_o !== 6'd11) begin
      n_err++;
      $display("FAIL early_wlast_bresp: got resp=%b id=%0d want resp=10 id=11", resp, id_o);
    end
    n_cmp++;
    axi_read(32'h300, 4'd3, 6'd11, 2'b01, 3'b011, lat, id_o);
    if (rbuf[3] !== 64'hC0C0_0000_0000_0003 || rbuf[1] !== 64'hC0C0_0000_0000_0001) begin
      n_err++;
      $display("FAIL early_wlast_data: got %h %h want c0c0000000000001 c0c0000000000003", rbuf[1], rbuf[3]);
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid_read();
    logic [5:0] id_o;
    int         lat;
    araddr = 32'h100; arlen = 4'd3; arid = 6'd12; arburst = 2'b01; arsize = 3'b011; arvalid = 1'b1;
    rready = 1'b0;
    wait_for("arready", arready);
    tick();
    arvalid = 1'b0;
    wait_for("rvalid", rvalid);
    Rst = 1'b1;
    tick();
    if ({awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rlast, rresp, rid} !== '0) begin
      n_err++;
      $display("FAIL midread_reset: got %h want 0",
               {awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rlast, rresp, rid});
    end
    n_cmp++;
    Rst = 1'b0;
    tick();
    if ({awready, arready, rvalid} !== 3'b110) begin
      n_err++;
      $display("FAIL midread_recover: got %b want 110", {awready, arready, rvalid});
    end
    n_cmp++;
    axi_read(32'h108, 4'd0, 6'd13, 2'b01, 3'b011, lat, id_o);
    if (rbuf[0] !== 64'h2222_2222_2222_2222 || lbuf[0] !== 1'b1 || pbuf[0] !== 2'b00 || id_o !== 6'd13) begin
      n_err++;
      $display("FAIL midread_new_burst: got d=%h last=%b resp=%b id=%0d want d=2222222222222222 last=1 resp=00 id=13",
               rbuf[0], lbuf[0], pbuf[0], id_o);
    end
    n_cmp++;
  endtask

  initial begin
    Rst = 1'b1;
    awvalid = 1'b0; awaddr = '0; awlen = '0; awid = '0; awsize = '0; awburst = '0;
    awlock = '0; awcache = '0; awprot = '0; awqos = '0;
    wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; wid = '0; bready = 1'b0;
    arvalid = 1'b0; araddr = '0; arlen = '0; arid = '0; arsize = '0; arburst = '0;
    arlock = '0; arcache = '0; arprot = '0; arqos = '0; rready = 1'b0;

    test_reset();
    test_incr();
    test_strobe();
    test_wrap();
    test_illegal();
    test_stall();
    test_early_wlast();
    test_reset_mid_read();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
